// File: rtl/wb_pkg.sv
// Shared Wishbone RAM slave definitions: bus widths, wait-counter width, FSM states.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_CNT_W  = 4;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_ram_core.sv
// Byte-enable synchronous RAM with a registered read port; maps onto block RAM.
module wb_ram_core
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WB_SEL_W-1:0]   sel,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WB_DATA_W-1:0]  wdata,
    output logic [WB_DATA_W-1:0]  rdata
);

    logic [WB_DATA_W-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (sel[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave over wb_ram_core with programmable wait states and cyc abort.
// Optional WB_RANGE_CHECK_EN adds wishbone_err_o for accesses outside BASE_ADDR's region.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wishbone_addr_i,
    input  logic [WB_DATA_W-1:0]  wishbone_data_i,
    input  logic                  wishbone_we_i,
    input  logic [WB_SEL_W-1:0]   wishbone_sel_i,
    input  logic                  wishbone_stb_i,
    input  logic                  wishbone_cyc_i,
    output logic [WB_DATA_W-1:0]  wishbone_data_o,
    output logic                  wishbone_ack_o
`ifdef WB_RANGE_CHECK_EN
    , output logic                wishbone_err_o
`endif
);

    wb_state_e             state, state_next;
    logic [WB_CNT_W-1:0]   cnt, cnt_next;
    logic                  go_resp;
    logic                  req;

    logic [ADDR_WIDTH-1:0] lat_idx;
    logic                  lat_we;
    logic [WB_SEL_W-1:0]   lat_sel;
    logic [WB_DATA_W-1:0]  lat_data;
    logic                  lat_bad;

    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_we;
    logic [WB_SEL_W-1:0]   cur_sel;
    logic [WB_DATA_W-1:0]  cur_data;
    logic                  cur_bad;
    logic                  in_bad;

    logic                  resp_bad;
    logic                  resp_we;
    logic                  ram_we;
    logic [WB_DATA_W-1:0]  ram_rdata;
    logic                  unused_bits;

    assign req = wishbone_cyc_i & wishbone_stb_i;

`ifdef WB_RANGE_CHECK_EN
    assign in_bad = (wishbone_addr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
`else
    assign in_bad = 1'b0;
`endif
    assign unused_bits = ^{wishbone_addr_i[1:0], wishbone_addr_i[31:ADDR_WIDTH+2], BASE_ADDR};

    // With zero wait states the RAM is accessed on the capture edge itself,
    // so the live bus must feed the RAM while still in IDLE.
    always_comb begin
        if (state == WB_S_IDLE) begin
            cur_idx  = wishbone_addr_i[ADDR_WIDTH+1:2];
            cur_we   = wishbone_we_i;
            cur_sel  = wishbone_sel_i;
            cur_data = wishbone_data_i;
            cur_bad  = in_bad;
        end else begin
            cur_idx  = lat_idx;
            cur_we   = lat_we;
            cur_sel  = lat_sel;
            cur_data = lat_data;
            cur_bad  = lat_bad;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_resp    = 1'b0;
        case (state)
            WB_S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = WB_S_RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WB_S_WAIT;
                        cnt_next   = WB_CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WB_S_WAIT: begin
                if (!wishbone_cyc_i) begin
                    state_next = WB_S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = WB_S_RESP;
                    go_resp    = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WB_S_RESP: state_next = WB_S_IDLE;
            default:   state_next = WB_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WB_S_IDLE;
            cnt      <= '0;
            resp_bad <= 1'b0;
            resp_we  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (go_resp) begin
                resp_bad <= cur_bad;
                resp_we  <= cur_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == WB_S_IDLE && req) begin
            lat_idx  <= wishbone_addr_i[ADDR_WIDTH+1:2];
            lat_we   <= wishbone_we_i;
            lat_sel  <= wishbone_sel_i;
            lat_data <= wishbone_data_i;
            lat_bad  <= in_bad;
        end
    end

    // Commit happens only on the edge that enters RESP; aborts and resets never write.
    assign ram_we = go_resp & cur_we & ~cur_bad & ~rst;

    wb_ram_core #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk  (clk),
        .we   (ram_we),
        .sel  (cur_sel),
        .waddr(cur_idx),
        .raddr(cur_idx),
        .wdata(cur_data),
        .rdata(ram_rdata)
    );

    assign wishbone_ack_o  = (state == WB_S_RESP) & ~resp_bad;
    assign wishbone_data_o = (wishbone_ack_o & ~resp_we) ? ram_rdata : '0;
`ifdef WB_RANGE_CHECK_EN
    assign wishbone_err_o  = (state == WB_S_RESP) & resp_bad;
`endif

endmodule
